// File: rtl/rr_sel_arbiter.sv
// Round-robin select generator for the 2**_N-input datapath mux.
// Registered sel/gnt with valid/ready handshake and capped locked bursts.
module rr_sel_arbiter #(
  parameter int _N       = 5,
  parameter int _MAXLOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [(1<<_N)-1:0]   req,
  input  logic                 lock,
  input  logic                 out_rdy,
  output logic                 out_v,
  output logic [_N-1:0]        sel,
  output logic [(1<<_N)-1:0]   gnt
);
  localparam int NREQ = 1 << _N;
  localparam int BW   = $clog2(_MAXLOCK) + 1;
  localparam logic [BW-1:0] LOCK_LAST = BW'(_MAXLOCK - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [_N-1:0]     sel_q, sel_d;
  logic [_N-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [_N-1:0]     sel_nxt;

  // First set bit of r at or above start, wrapping; start if none set.
  function automatic logic [_N-1:0] pick(input logic [NREQ-1:0] r,
                                         input logic [_N-1:0]   start);
    logic [_N-1:0] idx;
    logic          found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = start + i[_N-1:0];
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign sel_nxt = sel_q + _N'(1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = pick(req, ptr_q);
          gnt_d   = NREQ'(1) << sel_d;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (out_rdy) begin
          if (lock && req[sel_q] && (bcnt_q < LOCK_LAST)) begin
            bcnt_d = bcnt_q + BW'(1);
          end else begin
            ptr_d  = sel_nxt;
            bcnt_d = '0;
            if (|req) begin
              // back-to-back: next winner registered on the accepting edge
              sel_d = pick(req, sel_nxt);
              gnt_d = NREQ'(1) << sel_d;
            end else begin
              gnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign out_v = (state_q == GRANT);
  assign sel   = sel_q;
  assign gnt   = gnt_q;

  always @(posedge clk) begin
    if (rst_n) assert (!$isunknown(req)) else $error("req has X/Z bits");
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter (_N=2, _MAXLOCK=4): predicted outputs queued per
// driven cycle, popped and compared after the edge; plus directed sequences.
module tb_rr_sel_arbiter;
  localparam int N  = 2;
  localparam int NR = 4;
  localparam int ML = 4;

  logic          clk, rst_n;
  logic [NR-1:0] req;
  logic          lock, out_rdy;
  logic          out_v;
  logic [N-1:0]  sel;
  logic [NR-1:0] gnt;

  rr_sel_arbiter #(._N(N), ._MAXLOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .out_rdy(out_rdy),
    .out_v(out_v), .sel(sel), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [N-1:0]  sel;
    logic [NR-1:0] gnt;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // reference state
  logic m_v;
  int   m_sel, m_ptr, m_bcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mpick(input logic [NR-1:0] r, input int start);
    for (int k = 0; k < NR; k++)
      if (r[(start + k) % NR]) return (start + k) % NR;
    return start;
  endfunction

  task automatic model_push(input logic [NR-1:0] r, input logic l, input logic rdy);
    exp_t e;
    if (!m_v) begin
      if (r != 0) begin
        m_sel = mpick(r, m_ptr);
        m_v   = 1'b1;
      end
    end else if (rdy) begin
      if (l && r[m_sel] && m_bcnt < ML - 1) begin
        m_bcnt++;
      end else begin
        m_ptr  = (m_sel + 1) % NR;
        m_bcnt = 0;
        if (r != 0) m_sel = mpick(r, m_ptr);
        else        m_v   = 1'b0;
      end
    end
    e.v   = m_v;
    e.sel = m_sel[N-1:0];
    e.gnt = m_v ? (NR'(1) << m_sel) : '0;
    sbq.push_back(e);
  endtask

  // drive one cycle, predict, clock, compare
  task automatic cyc(input logic [NR-1:0] r, input logic l, input logic rdy);
    exp_t e;
    req = r; lock = l; out_rdy = rdy;
    model_push(r, l, rdy);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("sb_v", out_v, e.v);
      if (e.v) chk("sb_sel", sel, e.sel);
      chk("sb_gnt", gnt, e.gnt);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '1; out_rdy = 1'b1; lock = 1'b0;
    sbq.delete();
    m_v = 1'b0; m_sel = 0; m_ptr = 0; m_bcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", out_v, 0);
    chk("rst_sel", sel, 0);
    chk("rst_gnt", gnt, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_v", out_v, 0);
  endtask

  initial begin
    int rot_exp[4]   = '{1, 3, 1, 3};
    int burst_exp[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int wrap_exp[4]  = '{3, 0, 3, 3};
    rst_n = 1'b0; req = '0; lock = 1'b0; out_rdy = 1'b0;

    // reset with all requesting, then first grant
    do_reset();
    cyc(4'b1111, 0, 1);
    chk("first_v", out_v, 1);
    chk("first_sel", sel, 0);
    chk("first_gnt", gnt, 4'b0001);

    // rotation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1010, 0, 1);
      chk("rot_sel", sel, rot_exp[i]);
      chk("rot_v", out_v, 1);
    end

    // backpressure, req drops before acceptance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc((i < 2) ? 4'b0100 : 4'b0000, 0, 0);
      chk("bp_sel", sel, 2);
      chk("bp_gnt", gnt, 4'b0100);
    end
    cyc(4'b0000, 0, 1);
    chk("bp_drain_v", out_v, 0);
    chk("bp_drain_gnt", gnt, 0);

    // locked bursts capped at ML
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(4'b0011, 1, 1);
      chk("burst_sel", sel, burst_exp[i]);
    end

    // wrap-around and sole requester re-win
    do_reset();
    cyc(4'b1000, 0, 1);
    chk("wrap_sel", sel, wrap_exp[0]);
    cyc(4'b1001, 0, 1);
    chk("wrap_sel", sel, wrap_exp[1]);
    cyc(4'b1001, 0, 1);
    chk("wrap_sel", sel, wrap_exp[2]);
    cyc(4'b1000, 0, 1);
    chk("wrap_sel", sel, wrap_exp[3]);

    // async reset between edges while holding a grant
    do_reset();
    cyc(4'b0100, 0, 0);
    chk("mid_sel", sel, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_v", out_v, 0);
    chk("async_gnt", gnt, 0);
    chk("async_sel", sel, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbq.delete();
    m_v = 1'b0; m_sel = 0; m_ptr = 0; m_bcnt = 0;
    cyc(4'b0110, 0, 1);
    chk("post_rst_sel", sel, 1);

    // random traffic against the reference
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(4'($urandom_range(0, 15)) & ((i % 7 == 0) ? 4'b0000 : 4'b1111),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
